// File: rtl/pong_game_ctrl_if.sv
// rtl/pong_game_ctrl_if.sv - key, frame and miss inputs plus game outputs of the pong sequencer
interface pong_game_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic               i_Space;
    logic               i_P1_Up;
    logic               i_P1_Dn;
    logic               i_P2_Up;
    logic               i_P2_Dn;
    logic               i_Frame_Tick;
    logic               i_P1_Miss;
    logic               i_P2_Miss;
    logic [2:0]         o_State;
    logic               o_Ball_En;
    logic               o_Ball_Reset;
    logic               o_Serve_Dir;
    logic [SCORE_W-1:0] o_P1_Score;
    logic [SCORE_W-1:0] o_P2_Score;
    logic               o_P1_Up_Step;
    logic               o_P1_Dn_Step;
    logic               o_P2_Up_Step;
    logic               o_P2_Dn_Step;
    logic [1:0]         o_Winner;

    modport master (
        output i_Space, i_P1_Up, i_P1_Dn, i_P2_Up, i_P2_Dn,
               i_Frame_Tick, i_P1_Miss, i_P2_Miss,
        input  o_State, o_Ball_En, o_Ball_Reset, o_Serve_Dir,
               o_P1_Score, o_P2_Score, o_P1_Up_Step, o_P1_Dn_Step,
               o_P2_Up_Step, o_P2_Dn_Step, o_Winner
    );

    modport slave (
        input  i_Space, i_P1_Up, i_P1_Dn, i_P2_Up, i_P2_Dn,
               i_Frame_Tick, i_P1_Miss, i_P2_Miss,
        output o_State, o_Ball_En, o_Ball_Reset, o_Serve_Dir,
               o_P1_Score, o_P2_Score, o_P1_Up_Step, o_P1_Dn_Step,
               o_P2_Up_Step, o_P2_Dn_Step, o_Winner
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game-flow sequencer: serve/play/score/win, per-frame paddle steps
// Optional pause state in PLAY enabled by defining PONG_PAUSE_EN.
module pong_game_ctrl #(
    parameter int WIN_SCORE   = 5,
    parameter int SERVE_DELAY = 60,
    parameter int SCORE_W     = 4
) (
    input  logic           i_Clock,
    input  logic           i_Rst_n,
    pong_game_ctrl_if.slave bus
);
    localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SERVE     = 3'd1;
    localparam logic [2:0] ST_PLAY      = 3'd2;
    localparam logic [2:0] ST_POINT     = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;
`ifdef PONG_PAUSE_EN
    localparam logic [2:0] ST_PAUSE     = 3'd5;
`endif

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_DELAY - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

    logic [2:0]         state;
    logic [CNT_W-1:0]   serve_cnt;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [SCORE_W-1:0] p1_score_inc;
    logic [SCORE_W-1:0] p2_score_inc;
    logic [1:0]         winner;
    logic               ball_en;
    logic               ball_reset;
    logic               serve_dir;
    logic [3:0]         steps;
    logic               step_ok;
    logic [3:0]         step_req;

    assign p1_score_inc = p1_score + SCORE_W'(1);
    assign p2_score_inc = p2_score + SCORE_W'(1);

    // Paddles move only while the ball is live or waiting to serve; opposing keys cancel.
    assign step_ok  = bus.i_Frame_Tick && (state == ST_SERVE || state == ST_PLAY);
    assign step_req = {bus.i_P1_Up & ~bus.i_P1_Dn, bus.i_P1_Dn & ~bus.i_P1_Up,
                       bus.i_P2_Up & ~bus.i_P2_Dn, bus.i_P2_Dn & ~bus.i_P2_Up};

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= ST_IDLE;
            serve_cnt  <= '0;
            p1_score   <= '0;
            p2_score   <= '0;
            winner     <= 2'd0;
            ball_en    <= 1'b0;
            ball_reset <= 1'b0;
            serve_dir  <= 1'b0;
            steps      <= 4'b0;
        end else begin
            ball_reset <= 1'b0;
            steps      <= step_ok ? step_req : 4'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_Space) begin
                        state      <= ST_SERVE;
                        serve_cnt  <= '0;
                        ball_reset <= 1'b1;
                        serve_dir  <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    if (bus.i_Frame_Tick) begin
                        if (serve_cnt == CNT_LAST) begin
                            serve_cnt <= '0;
                            state     <= ST_PLAY;
                            ball_en   <= 1'b1;
                        end else begin
                            serve_cnt <= serve_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    // A P1 miss shadows a simultaneous P2 miss; any miss shadows space.
                    if (bus.i_P1_Miss) begin
                        p2_score  <= p2_score_inc;
                        serve_dir <= 1'b1;
                        ball_en   <= 1'b0;
                        if (p2_score_inc == WIN_VAL) begin
                            state  <= ST_GAME_OVER;
                            winner <= 2'd2;
                        end else begin
                            state      <= ST_POINT;
                            ball_reset <= 1'b1;
                        end
                    end else if (bus.i_P2_Miss) begin
                        p1_score  <= p1_score_inc;
                        serve_dir <= 1'b0;
                        ball_en   <= 1'b0;
                        if (p1_score_inc == WIN_VAL) begin
                            state  <= ST_GAME_OVER;
                            winner <= 2'd1;
                        end else begin
                            state      <= ST_POINT;
                            ball_reset <= 1'b1;
                        end
                    end
`ifdef PONG_PAUSE_EN
                    else if (bus.i_Space) begin
                        state   <= ST_PAUSE;
                        ball_en <= 1'b0;
                    end
`endif
                end
                ST_POINT: begin
                    state     <= ST_SERVE;
                    serve_cnt <= '0;
                end
                ST_GAME_OVER: begin
                    if (bus.i_Space) begin
                        state    <= ST_IDLE;
                        p1_score <= '0;
                        p2_score <= '0;
                        winner   <= 2'd0;
                    end
                end
`ifdef PONG_PAUSE_EN
                ST_PAUSE: begin
                    if (bus.i_Space) begin
                        state   <= ST_PLAY;
                        ball_en <= 1'b1;
                    end
                end
`endif
                default: begin
                    state   <= ST_IDLE;
                    ball_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_State      = state;
    assign bus.o_Ball_En    = ball_en;
    assign bus.o_Ball_Reset = ball_reset;
    assign bus.o_Serve_Dir  = serve_dir;
    assign bus.o_P1_Score   = p1_score;
    assign bus.o_P2_Score   = p2_score;
    assign bus.o_Winner     = winner;
    assign bus.o_P1_Up_Step = steps[3];
    assign bus.o_P1_Dn_Step = steps[2];
    assign bus.o_P2_Up_Step = steps[1];
    assign bus.o_P2_Dn_Step = steps[0];
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - randomized bench for pong_game_ctrl against a game-rule model
module tb_pong_game_ctrl;
    localparam int WIN = 5;
    localparam int SD  = 3;
    localparam int SW  = 4;

    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4, S_PAUSE = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pong_game_ctrl_if #(.SCORE_W(SW)) bus ();

    pong_game_ctrl #(.WIN_SCORE(WIN), .SERVE_DELAY(SD), .SCORE_W(SW)) dut (
        .i_Clock (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int       m_state, m_ticks, m_p1, m_p2, m_win, m_dir;
    bit       m_ben, m_brst;
    bit [3:0] m_steps;
    bit       did_directed_rst = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_ticks = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0;
        m_ben = 0; m_brst = 0; m_steps = 4'b0;
    endtask

    // One clock of game rules, applied to the inputs the bench is holding.
    task automatic model_step();
        int  ns;
        int  pts;
        bit  live;
        ns     = m_state;
        m_brst = 0;
        live   = bus.i_Frame_Tick && (m_state == S_SERVE || m_state == S_PLAY);
        m_steps = live ? {bus.i_P1_Up && !bus.i_P1_Dn, bus.i_P1_Dn && !bus.i_P1_Up,
                          bus.i_P2_Up && !bus.i_P2_Dn, bus.i_P2_Dn && !bus.i_P2_Up} : 4'b0;
        case (m_state)
            S_IDLE: if (bus.i_Space) begin
                ns = S_SERVE; m_brst = 1; m_dir = 0; m_ticks = 0;
            end
            S_SERVE: if (bus.i_Frame_Tick) begin
                m_ticks++;
                if (m_ticks == SD) begin m_ticks = 0; ns = S_PLAY; end
            end
            S_PLAY: begin
                if (bus.i_P1_Miss || bus.i_P2_Miss) begin
                    if (bus.i_P1_Miss) begin m_p2++; pts = m_p2; m_dir = 1; end
                    else               begin m_p1++; pts = m_p1; m_dir = 0; end
                    if (pts == WIN) begin
                        ns = S_OVER; m_win = bus.i_P1_Miss ? 2 : 1;
                    end else begin
                        ns = S_POINT; m_brst = 1;
                    end
                end
`ifdef PONG_PAUSE_EN
                else if (bus.i_Space) ns = S_PAUSE;
`endif
            end
            S_POINT: begin ns = S_SERVE; m_ticks = 0; end
            S_OVER: if (bus.i_Space) begin
                ns = S_IDLE; m_p1 = 0; m_p2 = 0; m_win = 0;
            end
            S_PAUSE: if (bus.i_Space) ns = S_PLAY;
            default: ns = S_IDLE;
        endcase
        m_state = ns;
        m_ben   = (ns == S_PLAY);
    endtask

    task automatic compare_all();
        check("state",      bus.o_State,      m_state);
        check("ball_en",    bus.o_Ball_En,    m_ben);
        check("ball_reset", bus.o_Ball_Reset, m_brst);
        check("serve_dir",  bus.o_Serve_Dir,  m_dir);
        check("p1_score",   bus.o_P1_Score,   m_p1);
        check("p2_score",   bus.o_P2_Score,   m_p2);
        check("winner",     bus.o_Winner,     m_win);
        check("p1_up_step", bus.o_P1_Up_Step, m_steps[3]);
        check("p1_dn_step", bus.o_P1_Dn_Step, m_steps[2]);
        check("p2_up_step", bus.o_P2_Up_Step, m_steps[1]);
        check("p2_dn_step", bus.o_P2_Dn_Step, m_steps[0]);
    endtask

    task automatic clear_inputs();
        bus.i_Space = 0; bus.i_Frame_Tick = 0; bus.i_P1_Miss = 0; bus.i_P2_Miss = 0;
    endtask

    task automatic async_reset_check();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        bus.i_P1_Up = 0; bus.i_P1_Dn = 0; bus.i_P2_Up = 0; bus.i_P2_Dn = 0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            bus.i_Space      = ($urandom_range(0, 9) == 0);
            bus.i_Frame_Tick = ($urandom_range(0, 2) == 0);
            bus.i_P1_Miss    = ($urandom_range(0, 11) == 0);
            bus.i_P2_Miss    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) begin
                bus.i_P1_Up = $urandom_range(0, 1); bus.i_P1_Dn = $urandom_range(0, 1);
                bus.i_P2_Up = $urandom_range(0, 1); bus.i_P2_Dn = $urandom_range(0, 1);
            end
            @(posedge clk);
            model_step();
            #1;
            compare_all();
            clear_inputs();
            if (!did_directed_rst && m_state == S_PLAY && m_p1 + m_p2 >= 3) begin
                did_directed_rst = 1;
                async_reset_check();
            end else if ($urandom_range(0, 999) == 0) begin
                async_reset_check();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
